// File: rtl/ldpc_pkg.sv
// rtl/ldpc_pkg.sv - shared LDPC constants: default block size and zero-block shift sentinel
package ldpc_pkg;

  localparam int MAX_BLOCK_SIZE_DEFAULT = 64;

  // The zero-block sentinel is an all-ones shift field of whatever width the user needs.
  localparam logic ZERO_BLOCK_SHIFT_BIT = 1'b1;

endpackage

// File: rtl/rotate_right_pipe_if.sv
// rtl/rotate_right_pipe_if.sv - input/output handshake bundle for rotate_right_pipe (out_err under ROTR_RANGE_CHECK_EN)
interface rotate_right_pipe_if #(
  parameter int MAX_BLOCK_SIZE = ldpc_pkg::MAX_BLOCK_SIZE_DEFAULT
);
  localparam int WIDTH = $clog2(MAX_BLOCK_SIZE);

  logic                      in_valid;
  logic                      in_ready;
  logic [MAX_BLOCK_SIZE-1:0] in_vector;
  logic [WIDTH-1:0]          shift_amount;
  logic [WIDTH-1:0]          width;
  logic                      out_valid;
  logic                      out_ready;
  logic [MAX_BLOCK_SIZE-1:0] out_vector;
`ifdef ROTR_RANGE_CHECK_EN
  logic                      out_err;
`endif

  modport master (
    output in_valid, in_vector, shift_amount, width, out_ready,
    input  in_ready, out_valid,
`ifdef ROTR_RANGE_CHECK_EN
           out_err,
`endif
           out_vector
  );

  modport slave (
    input  in_valid, in_vector, shift_amount, width, out_ready,
    output in_ready, out_valid,
`ifdef ROTR_RANGE_CHECK_EN
           out_err,
`endif
           out_vector
  );

endinterface

// File: rtl/rotr_stage.sv
// rtl/rotr_stage.sv - one pipeline stage: rotate MSB-aligned field right by 2**STAGE_K mod width when shift bit STAGE_K is set (err pass-through under ROTR_RANGE_CHECK_EN)
module rotr_stage
  import ldpc_pkg::*;
#(
  parameter int MAX_BLOCK_SIZE = MAX_BLOCK_SIZE_DEFAULT,
  parameter int STAGE_K        = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                advance,
  input  logic                                in_valid,
  input  logic [MAX_BLOCK_SIZE-1:0]           in_data,
  input  logic [$clog2(MAX_BLOCK_SIZE)-1:0]   in_width,
  input  logic [$clog2(MAX_BLOCK_SIZE)-1:0]   in_shift,
`ifdef ROTR_RANGE_CHECK_EN
  input  logic                                in_err,
  output logic                                out_err,
`endif
  output logic                                out_valid,
  output logic [MAX_BLOCK_SIZE-1:0]           out_data,
  output logic [$clog2(MAX_BLOCK_SIZE)-1:0]   out_width,
  output logic [$clog2(MAX_BLOCK_SIZE)-1:0]   out_shift
);
  localparam int WIDTH = $clog2(MAX_BLOCK_SIZE);
  localparam logic [WIDTH-1:0] STEP = WIDTH'(1 << STAGE_K);

  logic                      valid_q, valid_d;
  logic [MAX_BLOCK_SIZE-1:0] data_q, data_d;
  logic [WIDTH-1:0]          width_q, width_d;
  logic [WIDTH-1:0]          shift_q, shift_d;
  logic [WIDTH-1:0]          rot;
  logic [MAX_BLOCK_SIZE-1:0] mask;
  logic [MAX_BLOCK_SIZE-1:0] rotated;
`ifdef ROTR_RANGE_CHECK_EN
  logic                      err_q, err_d;
`endif

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    width_d = width_q;
    shift_d = shift_q;
`ifdef ROTR_RANGE_CHECK_EN
    err_d   = err_q;
`endif
    rot  = (in_width == '0) ? '0 : (STEP % in_width);
    mask = ~({MAX_BLOCK_SIZE{1'b1}} >> in_width);
    // Field sits in the top in_width bits; the left shift wraps its low bits to the top.
    rotated = ((in_data >> rot) | (in_data << (in_width - rot))) & mask;
    if (advance) begin
      valid_d = in_valid;
      data_d  = in_shift[STAGE_K] ? rotated : in_data;
      width_d = in_width;
      shift_d = in_shift;
`ifdef ROTR_RANGE_CHECK_EN
      err_d   = in_err;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      width_q <= '0;
      shift_q <= '0;
`ifdef ROTR_RANGE_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      width_q <= width_d;
      shift_q <= shift_d;
`ifdef ROTR_RANGE_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_width = width_q;
  assign out_shift = shift_q;
`ifdef ROTR_RANGE_CHECK_EN
  assign out_err   = err_q;
`endif

endmodule

// File: rtl/rotate_right_pipe.sv
// rtl/rotate_right_pipe.sv - WIDTH+1 stage circulant right-rotator, inverse of the decoder's left rotator (range check under ROTR_RANGE_CHECK_EN)
module rotate_right_pipe
  import ldpc_pkg::*;
#(
  parameter int MAX_BLOCK_SIZE = MAX_BLOCK_SIZE_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  rotate_right_pipe_if.slave bus
);
  localparam int WIDTH = $clog2(MAX_BLOCK_SIZE);
  localparam logic [WIDTH-1:0] ZERO_SHIFT = {WIDTH{ZERO_BLOCK_SHIFT_BIT}};

  logic                      advance;
  logic                      in_valid_q, in_valid_d;
  logic [MAX_BLOCK_SIZE-1:0] in_data_q, in_data_d;
  logic [WIDTH-1:0]          in_width_q, in_width_d;
  logic [WIDTH-1:0]          in_shift_q, in_shift_d;
  logic [MAX_BLOCK_SIZE-1:0] in_mask;
  logic                      blank;
`ifdef ROTR_RANGE_CHECK_EN
  logic                      in_err_q, in_err_d;
  logic                      range_err;
  logic                      stg_err [WIDTH+1];
`endif

  logic                      stg_valid [WIDTH+1];
  logic [MAX_BLOCK_SIZE-1:0] stg_data  [WIDTH+1];
  logic [WIDTH-1:0]          stg_width [WIDTH+1];
  logic [WIDTH-1:0]          stg_shift [WIDTH+1];
  logic                      unused_tail;

  // Whole pipeline moves in lockstep; a held output freezes every stage.
  assign advance      = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = advance;

  always_comb begin
    in_valid_d = in_valid_q;
    in_data_d  = in_data_q;
    in_width_d = in_width_q;
    in_shift_d = in_shift_q;
    in_mask    = ~({MAX_BLOCK_SIZE{1'b1}} >> bus.width);
    blank      = (bus.shift_amount == ZERO_SHIFT) || (bus.width == '0);
`ifdef ROTR_RANGE_CHECK_EN
    in_err_d   = in_err_q;
    range_err  = (bus.shift_amount != ZERO_SHIFT) && (bus.shift_amount >= bus.width);
    blank      = blank || range_err;
`endif
    if (advance) begin
      in_valid_d = bus.in_valid;
      in_data_d  = blank ? '0 : (bus.in_vector & in_mask);
      in_width_d = bus.width;
      in_shift_d = bus.shift_amount;
`ifdef ROTR_RANGE_CHECK_EN
      in_err_d   = range_err;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_valid_q <= 1'b0;
      in_data_q  <= '0;
      in_width_q <= '0;
      in_shift_q <= '0;
`ifdef ROTR_RANGE_CHECK_EN
      in_err_q   <= 1'b0;
`endif
    end else begin
      in_valid_q <= in_valid_d;
      in_data_q  <= in_data_d;
      in_width_q <= in_width_d;
      in_shift_q <= in_shift_d;
`ifdef ROTR_RANGE_CHECK_EN
      in_err_q   <= in_err_d;
`endif
    end
  end

  assign stg_valid[0] = in_valid_q;
  assign stg_data[0]  = in_data_q;
  assign stg_width[0] = in_width_q;
  assign stg_shift[0] = in_shift_q;
`ifdef ROTR_RANGE_CHECK_EN
  assign stg_err[0]   = in_err_q;
`endif

  // Stage k rotates by 2**k mod width; together they sum to shift_amount for in-range shifts.
  for (genvar k = 0; k < WIDTH; k++) begin : g_stage
    rotr_stage #(
      .MAX_BLOCK_SIZE (MAX_BLOCK_SIZE),
      .STAGE_K        (k)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .advance   (advance),
      .in_valid  (stg_valid[k]),
      .in_data   (stg_data[k]),
      .in_width  (stg_width[k]),
      .in_shift  (stg_shift[k]),
`ifdef ROTR_RANGE_CHECK_EN
      .in_err    (stg_err[k]),
      .out_err   (stg_err[k+1]),
`endif
      .out_valid (stg_valid[k+1]),
      .out_data  (stg_data[k+1]),
      .out_width (stg_width[k+1]),
      .out_shift (stg_shift[k+1])
    );
  end

  assign bus.out_valid  = stg_valid[WIDTH];
  assign bus.out_vector = stg_data[WIDTH];
`ifdef ROTR_RANGE_CHECK_EN
  assign bus.out_err    = stg_err[WIDTH];
`endif
  assign unused_tail    = ^{stg_width[WIDTH], stg_shift[WIDTH]};

endmodule

// File: tb/tb_rotate_right_pipe.sv
// tb/tb_rotate_right_pipe.sv - directed bench for rotate_right_pipe at MAX_BLOCK_SIZE=8 (extra checks under ROTR_RANGE_CHECK_EN)
module tb_rotate_right_pipe;
  localparam int MBS = 8;

  typedef struct {
    logic [7:0] vin;
    logic [2:0] shift;
    logic [2:0] width;
    logic [7:0] vexp;
    logic       verr;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errs   = 0;

  vec_t       vecs[$];
  logic [7:0] s_in [16];
  logic [7:0] s_exp[16];
  logic [2:0] s_sh [16];
  logic [2:0] s_w  [16];

  rotate_right_pipe_if #(.MAX_BLOCK_SIZE(MBS)) bus ();

  rotate_right_pipe #(.MAX_BLOCK_SIZE(MBS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errs++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rotl(input logic [7:0] v, input int s, input int w);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < w; i++) r[8 - w + ((i + s) % w)] = v[8 - w + i];
    return r;
  endfunction

  task automatic drive(input logic [7:0] v, input logic [2:0] s, input logic [2:0] w);
    bus.in_vector    = v;
    bus.shift_amount = s;
    bus.width        = w;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    drive(v.vin, v.shift, v.width);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check($sformatf("in_ready_v%0d", idx), bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check($sformatf("latency_v%0d", idx), lat, 4);
    check($sformatf("out_vector_v%0d", idx), bus.out_vector, v.vexp);
`ifdef ROTR_RANGE_CHECK_EN
    check($sformatf("out_err_v%0d", idx), bus.out_err, v.verr);
`endif
    tick();
    check($sformatf("drained_v%0d", idx), bus.out_valid, 0);
  endtask

  task automatic stream(input int n, input int st0, input int stn, input string tag);
    int         sent, got, cyc, stall_cnt;
    bit         stalled, fire_in;
    logic [7:0] held;
    sent = 0; got = 0; cyc = 0; stall_cnt = 0; stalled = 0; held = '0;
    while (got < n && cyc < 100) begin
      bus.in_valid = (sent < n);
      if (sent < n) drive(s_in[sent], s_sh[sent], s_w[sent]);
      bus.out_ready = !(cyc >= st0 && cyc < st0 + stn);
      #1;
      if (stalled) begin
        check($sformatf("%s_hold_valid_c%0d", tag, cyc), bus.out_valid, 1);
        check($sformatf("%s_hold_data_c%0d", tag, cyc), bus.out_vector, held);
      end
      if (bus.out_valid && !bus.out_ready) begin
        check($sformatf("%s_in_ready_low_c%0d", tag, cyc), bus.in_ready, 0);
        stalled = 1;
        held    = bus.out_vector;
        stall_cnt++;
      end else begin
        stalled = 0;
      end
      if (bus.out_valid && bus.out_ready) begin
        check($sformatf("%s_beat%0d", tag, got), bus.out_vector, s_exp[got]);
        got++;
      end
      fire_in = bus.in_valid && bus.in_ready;
      tick();
      if (fire_in) sent++;
      cyc++;
    end
    bus.in_valid = 1'b0;
    check($sformatf("%s_count", tag), got, n);
    check($sformatf("%s_stall_cycles", tag), stall_cnt, stn);
    repeat (3) begin
      check($sformatf("%s_no_extra", tag), bus.out_valid, 0);
      tick();
    end
  endtask

  initial begin
    int lat;
    int sel[6];
    vecs.push_back('{8'hB5, 3'd1, 3'd5, 8'h58, 1'b0});
    vecs.push_back('{8'hFF, 3'd7, 3'd5, 8'h00, 1'b0});
    vecs.push_back('{8'hA5, 3'd2, 3'd0, 8'h00, 1'b0});
    vecs.push_back('{8'hA7, 3'd0, 3'd7, 8'hA6, 1'b0});
    vecs.push_back('{8'hD0, 3'd2, 3'd4, 8'h70, 1'b0});
    vecs.push_back('{8'h80, 3'd6, 3'd7, 8'h02, 1'b0});
    vecs.push_back('{8'h7F, 3'd2, 3'd3, 8'hC0, 1'b0});
    vecs.push_back('{8'hFF, 3'd0, 3'd1, 8'h80, 1'b0});
    vecs.push_back('{8'h83, 3'd5, 3'd6, 8'h04, 1'b0});
    vecs.push_back('{8'h0F, 3'd3, 3'd5, 8'h20, 1'b0});
    vecs.push_back('{8'h80, 3'd1, 3'd2, 8'h40, 1'b0});
    vecs.push_back('{8'hFF, 3'd7, 3'd7, 8'h00, 1'b0});
    vecs.push_back('{8'hD2, 3'd3, 3'd7, 8'h3A, 1'b0});
`ifdef ROTR_RANGE_CHECK_EN
    vecs.push_back('{8'hFF, 3'd5, 3'd4, 8'h00, 1'b1});
    vecs.push_back('{8'hD0, 3'd2, 3'd4, 8'h70, 1'b0});
`endif

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drive(8'h00, 3'd0, 3'd0);
    repeat (2) tick();
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_out_vector", bus.out_vector, 0);
`ifdef ROTR_RANGE_CHECK_EN
    check("reset_out_err", bus.out_err, 0);
`endif
    rst = 1'b0;
    check("reset_in_ready", bus.in_ready, 1);

    foreach (vecs[i]) run_vec(vecs[i], i);

    for (int i = 0; i < 8; i++) begin
      logic [7:0] v;
      int w, s;
      w = $urandom_range(1, 7);
      s = $urandom_range(0, w - 1);
      v = 8'($urandom);
      s_in[i]  = rotl(v, s, w);
      s_sh[i]  = 3'(s);
      s_w[i]   = 3'(w);
      s_exp[i] = v & (8'hFF << (8 - w));
    end
    stream(8, 0, 0, "roundtrip");

    sel = '{0, 3, 4, 5, 6, 7};
    for (int i = 0; i < 6; i++) begin
      s_in[i]  = vecs[sel[i]].vin;
      s_sh[i]  = vecs[sel[i]].shift;
      s_w[i]   = vecs[sel[i]].width;
      s_exp[i] = vecs[sel[i]].vexp;
    end
    stream(6, 5, 3, "backpressure");

    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(vecs[i + 3].vin, vecs[i + 3].shift, vecs[i + 3].width);
      bus.in_valid = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_cycle_out_valid", bus.out_valid, 0);
    tick();
    rst = 1'b0;
    check("post_rst_out_valid", bus.out_valid, 0);
    check("post_rst_out_vector", bus.out_vector, 0);
    check("post_rst_in_ready", bus.in_ready, 1);
    drive(8'hB5, 3'd1, 3'd5);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("post_rst_latency", lat, 4);
    check("post_rst_out_vector_new", bus.out_vector, 8'h58);
    tick();
    check("post_rst_drained", bus.out_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/rotate_right_pipe.md
ROTATE_RIGHT_PIPE -- requirements
Module: rotate_right_pipe

Interface
REQ-001 SHALL have parameter MAX_BLOCK_SIZE, default 64, meaning the data vector width and the largest circulant size.
REQ-002 SHALL have localparam WIDTH = $clog2(MAX_BLOCK_SIZE), meaning the bit width of shift and width fields.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, meaning the input beat is valid.
REQ-006 SHALL have port in_ready, output, 1, meaning the block accepts a beat this cycle.
REQ-007 SHALL have port in_vector, input, MAX_BLOCK_SIZE, meaning the circulant-shifted block, MSB-aligned.
REQ-008 SHALL have port shift_amount, input, WIDTH, meaning the right-rotate amount; all-ones means zero block.
REQ-009 SHALL have port width, input, WIDTH, meaning the number of effective MSBs.
REQ-010 SHALL have port out_valid, output, 1, meaning the result is valid.
REQ-011 SHALL have port out_ready, input, 1, meaning the downstream accepts the result.
REQ-012 SHALL have port out_vector, output, MAX_BLOCK_SIZE, meaning the rotated result, MSB-aligned, with LSBs zeroed.

Function
REQ-013 SHALL define the mask as the top `width` bits set; in_vector bits below the mask are ignored.
REQ-014 SHALL rotate the masked field right by shift_amount within the width-bit field, the exact inverse of the left circulant rotation used elsewhere in the decoder.
REQ-015 SHALL output all-zero out_vector when shift_amount == 2**WIDTH-1, regardless of width.
REQ-016 SHALL output all-zero out_vector when width == 0.
REQ-017 SHALL treat shift_amount >= width (non-sentinel) as out-of-range; data is don't-care unless ROTR_RANGE_CHECK_EN is defined.
REQ-018 SHALL use WIDTH+1 pipeline stages: one input register plus one conditional-rotate stage per shift bit k, rotating by 2**k mod width.
REQ-019 SHALL have a fixed latency of WIDTH+1 cycles from the accept edge to out_valid when there is no backpressure.
REQ-020 SHALL accept one beat per cycle; a transfer occurs on the edge where valid && ready.
REQ-021 SHALL drive in_ready = !out_valid || out_ready; the whole pipeline advances together, and bubbles are not compressed.
REQ-022 SHALL hold out_vector and out_valid stable while out_valid && !out_ready.
REQ-023 SHALL carry width and shift_amount alongside the data in each stage; no sideband is shared across beats.

Reset
REQ-024 SHALL clear every stage valid bit, out_valid, and out_vector to 0 on rst; data registers other than out_vector need not reset.
REQ-025 SHALL discard in-flight beats on rst asserted mid-operation; in_ready is 1 in the first cycle after rst deasserts.
REQ-026 SHALL take no accepts during rst cycles, and out_valid stays 0 during those cycles.

Configuration
REQ-027 SHALL, when ROTR_RANGE_CHECK_EN is defined, add output out_err (1 bit, aligned with out_valid, reset 0), set to 1 and force out_vector to 0 for out-of-range shift (REQ-017).
REQ-028 SHALL, without ROTR_RANGE_CHECK_EN, omit out_err and add no range-check logic.

Structure
REQ-029 SHALL take the MAX_BLOCK_SIZE default and the zero-block sentinel constant (all-ones shift) from shared package ldpc_pkg.
REQ-030 SHALL implement each conditional-rotate stage as sub-module rotr_stage (params MAX_BLOCK_SIZE, STAGE_K), instantiated WIDTH times via generate.

Verification (MAX_BLOCK_SIZE=8, WIDTH=3, latency 4)
REQ-031 SHALL check: width=5, shift=1, in=8'b10110_101 -> out 8'b01011_000 exactly 4 cycles after accept.
REQ-032 SHALL check: shift=3'b111, width=5, in=8'hFF -> out 8'h00; width=0, shift=2 -> out 8'h00.
REQ-033 SHALL check round-trip: random in, width 1..7, shift < width, fed through the left rotator then this block -> equals in masked to the top width bits.
REQ-034 SHALL check backpressure: 6 back-to-back beats, out_ready low for 3 cycles mid-stream -> in_ready low, outputs held stable, all 6 results in order, none lost or duplicated.
REQ-035 SHALL check reset: rst asserted for 1 cycle with 3 beats in flight -> no out_valid from those beats, out_valid 0 after reset, and a new beat accepted the cycle after rst deasserts.
REQ-036 SHALL check, with ROTR_RANGE_CHECK_EN: width=4, shift=5 -> out_err=1 and out 8'h00; width=4, shift=2 -> out_err=0.
